// File: rtl/fifo_coder_pkg.sv
// Shared types and constants for the FIFO_coder write side of the Huffman coder.
package fifo_coder_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned GRANT_W     = $clog2(NUM_REQ_DEF);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Width of a producer index; at least one bit.
  function automatic int unsigned grant_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_coder_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit strictly after rr_ptr, wrapping.
module rr_pick
  import fifo_coder_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned GW      = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      rr_ptr,
  output logic               found,
  output logic [GW-1:0]      index
);

  int unsigned     cand;
  logic [GW-1:0]   cidx;

  // Walk from farthest to nearest so the nearest valid index after rr_ptr wins.
  always_comb begin
    found = |req;
    index = '0;
    cand  = '0;
    cidx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_ptr) + NUM_REQ - k) % NUM_REQ;
      cidx = GW'(cand);
      if (req[cidx]) index = cidx;
    end
  end

endmodule

// File: rtl/fifo_coder_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO_coder write port between producers.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module fifo_coder_wr_arbiter
  import fifo_coder_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned DATA_W    = fifo_coder_pkg::DATA_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*DATA_W-1:0]        req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             fifo_wr,
  output logic [DATA_W-1:0]                fifo_data_in,
  input  logic                             fifo_full,
  input  logic                             fifo_threshold,
  output logic [grant_width(NUM_REQ)-1:0]  grant_id,
  output logic                             busy
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]            word_cnt,
  output logic [15:0]                      stall_cnt
`endif
);

  localparam int unsigned GW    = grant_width(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     rr_ptr, ptr_d, grant_d, pick_idx;
  logic [CNT_W-1:0]  burst_cnt, cnt_d, cnt_inc;
  logic              pick_found, in_burst, sel_valid, sel_last, xfer;
  logic [DATA_W-1:0] words [NUM_REQ];
  logic [DATA_W-1:0] sel_data;

  rr_pick #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .index  (pick_idx)
  );

  // State register; rr_ptr resets to the last index so producer 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_id  <= '0;
      rr_ptr    <= GW'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state_q   <= state_d;
      grant_id  <= grant_d;
      rr_ptr    <= ptr_d;
      burst_cnt <= cnt_d;
    end
  end

  // Granted-producer datapath; write is gated by fifo_full so overflow is impossible.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      words[k] = req_data[k*DATA_W +: DATA_W];
    end
    in_burst  = (state_q == ST_BURST);
    sel_valid = req_valid[grant_id];
    sel_last  = req_last[grant_id];
    sel_data  = words[grant_id];
    xfer      = in_burst & sel_valid & ~fifo_full;
    req_ready = '0;
    if (in_burst && !fifo_full) req_ready[grant_id] = 1'b1;
    fifo_wr      = xfer;
    fifo_data_in = in_burst ? sel_data : '0;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_id;
    ptr_d   = rr_ptr;
    cnt_d   = burst_cnt;
    cnt_inc = burst_cnt + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (pick_found && !fifo_threshold) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        // Only a completed transfer can end a burst; stalls and idle producers hold it.
        if (xfer) begin
          cnt_d = cnt_inc;
          if (sel_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
            state_d = ST_IDLE;
            ptr_d   = grant_id;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_BURST);

`ifdef ARB_STATS_EN
  logic [15:0] wc_q [NUM_REQ];

  // Saturating per-producer word counters and a stall-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) wc_q[k] <= '0;
      stall_cnt <= '0;
    end else begin
      if (xfer && (wc_q[grant_id] != 16'hFFFF)) wc_q[grant_id] <= wc_q[grant_id] + 16'd1;
      if (in_burst && sel_valid && fifo_full && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) word_cnt[k*16 +: 16] = wc_q[k];
  end
`endif

endmodule
